// File: rtl/store_merge_unit_if.sv
// rtl/store_merge_unit_if.sv - store request and data memory port bundle for store_merge_unit
interface store_merge_unit_if;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        misalign;

    modport master (
        output start, size, addr, wdata, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy, done, misalign
    );

    modport slave (
        input  start, size, addr, wdata, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, busy, done, misalign
    );
endinterface

// File: rtl/store_merge_unit.sv
// rtl/store_merge_unit.sv - word/half/byte store into word-addressed memory with read-modify-write
module store_merge_unit #(
    parameter int READ_WAIT  = 1,
    parameter int BYTE_ORDER = 0
) (
    input logic              clk,
    input logic              reset,
    store_merge_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;

    localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT);

    state_t      state;
    logic [2:0]  wait_cnt;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic [15:0] wdata_q;
    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [31:0] merged;
    logic        bad_req;

    // Big-endian lane k sits where little-endian lane ~k would, so flip the index once.
    always_comb begin
        byte_lane = (BYTE_ORDER != 0) ? ~addr_lo_q : addr_lo_q;
        half_lane = (BYTE_ORDER != 0) ? ~addr_lo_q[1] : addr_lo_q[1];
        merged    = bus.mem_rdata;
        if (size_q == 2'b01) begin
            if (half_lane) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end else begin
            case (byte_lane)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_comb begin
        bad_req = (bus.size == 2'b11) ||
                  (bus.size == 2'b01 && bus.addr[0]) ||
                  (bus.size == 2'b00 && bus.addr[1:0] != 2'b00);
    end

    // Outputs are registered on the transition into the state that owns them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= 3'd0;
            addr_lo_q     <= 2'b00;
            size_q        <= 2'b00;
            wdata_q       <= 16'h0;
            bus.mem_addr  <= 32'h0;
            bus.mem_wr    <= 1'b0;
            bus.mem_wdata <= 32'h0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.misalign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_lo_q <= bus.addr[1:0];
                        size_q    <= bus.size;
                        wdata_q   <= bus.wdata[15:0];
                        bus.busy  <= 1'b1;
                        if (bad_req) begin
                            state        <= ERR;
                            bus.misalign <= 1'b1;
                        end else if (bus.size == 2'b00) begin
                            state         <= WRITE;
                            bus.mem_addr  <= {bus.addr[31:2], 2'b00};
                            bus.mem_wr    <= 1'b1;
                            bus.mem_wdata <= bus.wdata;
                        end else begin
                            state        <= READ;
                            bus.mem_addr <= {bus.addr[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                WAIT: begin
                    if (wait_cnt == 3'd1) begin
                        state         <= WRITE;
                        wait_cnt      <= 3'd0;
                        bus.mem_wr    <= 1'b1;
                        bus.mem_wdata <= merged;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                WRITE: begin
                    state         <= DONE;
                    bus.mem_wr    <= 1'b0;
                    bus.mem_wdata <= 32'h0;
                    bus.done      <= 1'b1;
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                ERR: begin
                    state        <= IDLE;
                    bus.misalign <= 1'b0;
                    bus.busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_merge_unit.sv
// tb/tb_store_merge_unit.sv - table-driven scoreboard bench for store_merge_unit (LE/RW=1 and BE/RW=3)
module tb_store_merge_unit;
    localparam int RW0 = 1;
    localparam int RW1 = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    store_merge_unit_if bus0();
    store_merge_unit_if bus1();

    store_merge_unit #(.READ_WAIT(RW0), .BYTE_ORDER(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    store_merge_unit #(.READ_WAIT(RW1), .BYTE_ORDER(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    typedef struct {
        int          d;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
        logic [31:0] eaddr;
        logic [31:0] edata;
    } vec_t;

    typedef struct {
        bit          err;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_n = 0;
    int   last_wr[2] = '{-10, -10};
    vec_t vecs[15];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic mon(input int d, input logic wr, input logic [31:0] ma, input logic [31:0] md,
                       input logic mis, input logic dn);
        exp_t e;
        int   n;
        if (wr || mis) begin
            n = (d == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                tests++;
                fails++;
                $display("FAIL dut%0d unexpected op: got wr=%b misalign=%b expected none", d, wr, mis);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("dut%0d misalign kind", d), {31'b0, mis}, {31'b0, e.err});
                chk($sformatf("dut%0d op cycle", d), cyc_n, e.cyc);
                if (!e.err) begin
                    chk($sformatf("dut%0d mem_addr", d), ma, e.addr);
                    chk($sformatf("dut%0d mem_wdata", d), md, e.data);
                    last_wr[d] = cyc_n;
                end
            end
        end
        if (dn) chk($sformatf("dut%0d done cycle", d), cyc_n, last_wr[d] + 1);
        if (!wr) chk($sformatf("dut%0d mem_wdata idle", d), md, 32'h0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0, bus0.mem_wr, bus0.mem_addr, bus0.mem_wdata, bus0.misalign, bus0.done);
            mon(1, bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata, bus1.misalign, bus1.done);
        end
    end

    task automatic drive(input int d, input logic st, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (d == 0) begin
            bus0.start = st; bus0.size = sz; bus0.addr = ad; bus0.wdata = wd;
        end else begin
            bus1.start = st; bus1.size = sz; bus1.addr = ad; bus1.wdata = wd;
        end
    endtask

    task automatic set_rdata(input int d, input logic [31:0] v);
        if (d == 0) bus0.mem_rdata = v;
        else        bus1.mem_rdata = v;
    endtask

    function automatic logic busy_of(input int d);
        return (d == 0) ? bus0.busy : bus1.busy;
    endfunction

    // Called just after a rising edge; returns in the IDLE cycle following the store.
    task automatic run_store(input vec_t v, input bit noise);
        int   rw;
        int   t0;
        bit   idle;
        exp_t e;
        rw     = (v.d == 0) ? RW0 : RW1;
        t0     = cyc_n;
        e.err  = v.err;
        e.addr = v.eaddr;
        e.data = v.edata;
        e.cyc  = (v.err || v.size == 2'b00) ? t0 + 1 : t0 + 2 + rw;
        if (v.d == 0) q0.push_back(e);
        else          q1.push_back(e);
        drive(v.d, 1'b1, v.size, v.addr, v.wdata);
        set_rdata(v.d, 32'hBAD0_BAD0);
        idle = 1'b0;
        for (int k = 1; k <= 20 && !idle; k++) begin
            @(posedge clk); #1;
            if (noise && k <= 2) drive(v.d, 1'b1, 2'b00, 32'h0000_0040, 32'h1234_5678);
            else                 drive(v.d, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0);
            set_rdata(v.d, (cyc_n == t0 + 1 + rw) ? v.rdata : 32'hBAD0_BAD0);
            if (k == 1) chk($sformatf("dut%0d busy after start", v.d), {31'b0, busy_of(v.d)}, 32'h1);
            else if (!busy_of(v.d)) idle = 1'b1;
        end
        if (!idle) begin
            tests++;
            fails++;
            $display("FAIL dut%0d timeout: got busy stuck expected idle within 20 cycles", v.d);
        end
    endtask

    initial begin
        vecs[0]  = '{0, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         0, 32'h10,  32'hDEAD_BEEF};
        vecs[1]  = '{0, 2'b10, 32'h0000_0013, 32'hFFFF_FFAB, 32'h1122_3344, 0, 32'h10,  32'hAB22_3344};
        vecs[2]  = '{0, 2'b01, 32'h0000_0022, 32'h0000_CAFE, 32'h5566_7788, 0, 32'h20,  32'hCAFE_7788};
        vecs[3]  = '{0, 2'b01, 32'h0000_0020, 32'hFFFF_BEEF, 32'h5566_7788, 0, 32'h20,  32'h5566_BEEF};
        vecs[4]  = '{0, 2'b10, 32'h0000_0101, 32'h0000_005A, 32'h0000_0000, 0, 32'h100, 32'h0000_5A00};
        vecs[5]  = '{0, 2'b10, 32'h0000_0007, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0, 32'h4,   32'h00FF_FFFF};
        vecs[6]  = '{0, 2'b01, 32'h0000_0021, 32'h0000_1111, 32'h0,         1, 32'h0,   32'h0};
        vecs[7]  = '{0, 2'b00, 32'h0000_0022, 32'h2222_2222, 32'h0,         1, 32'h0,   32'h0};
        vecs[8]  = '{0, 2'b11, 32'h0000_0040, 32'h3333_3333, 32'h0,         1, 32'h0,   32'h0};
        vecs[9]  = '{1, 2'b01, 32'h0000_0022, 32'h0000_CAFE, 32'h5566_7788, 0, 32'h20,  32'h5566_CAFE};
        vecs[10] = '{1, 2'b10, 32'h0000_0013, 32'h0000_00AB, 32'h1122_3344, 0, 32'h10,  32'h1122_33AB};
        vecs[11] = '{1, 2'b10, 32'h0000_0010, 32'h0000_00AB, 32'h1122_3344, 0, 32'h10,  32'hAB22_3344};
        vecs[12] = '{1, 2'b01, 32'h0000_0020, 32'h0000_BEEF, 32'h5566_7788, 0, 32'h20,  32'hBEEF_7788};
        vecs[13] = '{1, 2'b00, 32'h0000_000C, 32'hCAFE_F00D, 32'h0,         0, 32'hC,   32'hCAFE_F00D};
        vecs[14] = '{1, 2'b11, 32'h0000_0000, 32'h0,         32'h0,         1, 32'h0,   32'h0};

        drive(0, 1'b0, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
        set_rdata(0, 32'h0);
        set_rdata(1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset mem_addr0", bus0.mem_addr, 32'h0);
        chk("reset mem_wdata0", bus0.mem_wdata, 32'h0);
        chk("reset flags0", {28'b0, bus0.mem_wr, bus0.busy, bus0.done, bus0.misalign}, 32'h0);
        chk("reset mem_addr1", bus1.mem_addr, 32'h0);
        chk("reset mem_wdata1", bus1.mem_wdata, 32'h0);
        chk("reset flags1", {28'b0, bus1.mem_wr, bus1.busy, bus1.done, bus1.misalign}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_store(vecs[i], 1'b0);

        // Noisy starts while busy, then a back-to-back store in the next IDLE cycle.
        run_store(vecs[1], 1'b1);
        run_store(vecs[2], 1'b0);
        run_store(vecs[10], 1'b1);
        run_store(vecs[0], 1'b0);

        // Reset in the middle of a byte store's WAIT phase on the BE unit.
        drive(1, 1'b1, 2'b10, 32'h0000_0013, 32'h0000_00AB);
        set_rdata(1, 32'h1122_3344);
        @(posedge clk); #1;
        drive(1, 1'b0, 2'b00, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort flags immediate", {29'b0, bus1.mem_wr, bus1.busy, bus1.done}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort flags held", {29'b0, bus1.mem_wr, bus1.busy, bus1.done}, 32'h0);
        end
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no write after abort", {31'b0, bus1.mem_wr}, 32'h0);
        end
        @(posedge clk); #1;
        run_store(vecs[13], 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("scoreboard0 drained", q0.size(), 32'h0);
        chk("scoreboard1 drained", q1.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Memory-side counterpart of the register write-back path. It takes a register value plus SW/SH/SB size, performs the store into the word-addressed data memory, and does read-modify-write for sub-word sizes.
- Sits between the control unit and the memory port during store instructions.
- Produces the aligned word address, write strobe and merged write data.
- Reports completion to the control FSM, or raises a misalignment exception.

Parameters:
- READ_WAIT, 1, number of WAIT cycles after the read address is issued before mem_rdata is valid (range 1..7).
- BYTE_ORDER, 0, 0 = little-endian (byte 0 at bits [7:0]), 1 = big-endian (byte 0 at bits [31:24]).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled in IDLE only.
- size  input  2  00 = word, 01 = half, 10 = byte, 11 = reserved.
- addr  input  32  byte address (ALUOut).
- wdata  input  32  store data (register B); byte/half taken from low bits.
- mem_rdata  input  32  data memory read word.
- mem_addr  output  32  word-aligned memory address.
- mem_wr  output  1  memory write strobe.
- mem_wdata  output  32  word written to memory.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the store has been written.
- misalign  output  1  one-cycle pulse on an alignment or reserved-size error.

Behaviour:
- Reset (asynchronous, reset = 0): state IDLE, wait counter = 0, all outputs 0, latched addr/size/wdata cleared. Reset mid-operation aborts the store: mem_wr falls immediately and no partial write occurs afterwards.
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE, start = 1: latch addr, size and wdata. Next state:
  - ERR if size = 11, or size = 01 and addr[0] = 1, or size = 00 and addr[1:0] != 00.
  - WRITE if size = 00.
  - READ otherwise.
- start while busy is ignored; latched values are not disturbed.
- READ (1 cycle): mem_addr = {addr[31:2], 2'b00}, mem_wr = 0. Then go to WAIT, counter = READ_WAIT.
- WAIT: counter decrements each cycle. On the cycle it reaches 1, mem_rdata is captured into a merge register and the next state is WRITE.
- WRITE (1 cycle): mem_wr = 1, mem_addr held, mem_wdata as below.
  - Word: mem_wdata = wdata.
  - Half: the 16-bit lane selected by addr[1] is replaced by wdata[15:0]; other bits come from the captured word.
  - Byte: the 8-bit lane selected by addr[1:0] is replaced by wdata[7:0]; other bits come from the captured word.
  - Lane numbering follows BYTE_ORDER. For little-endian, lane k = bits [8k+7:8k]; half lane h = bits [16h+15:16h].
- DONE (1 cycle): done = 1, mem_wr = 0, then IDLE.
- ERR (1 cycle): misalign = 1. No memory access occurs (mem_wr never asserted). Then IDLE.
- Latency from the start cycle (cycle 0):
  - Word: WRITE at cycle 1, done at cycle 2.
  - Byte/half: READ at 1, WAIT at 2..1+READ_WAIT, WRITE at 2+READ_WAIT, done at 3+READ_WAIT.
  - Error: misalign at cycle 1.
- Outside READ/WAIT/WRITE, mem_addr holds its last value; mem_wdata is 0 outside WRITE.
- A new start is accepted in the IDLE cycle immediately after DONE/ERR, giving back-to-back stores with no bubble beyond IDLE.

Test Plan:
- Word store: addr = 0x00000010, size = 00, wdata = 0xDEADBEEF -> cycle 1 mem_wr = 1, mem_addr = 0x10, mem_wdata = 0xDEADBEEF; cycle 2 done = 1; READ never entered.
- Byte store, little-endian, READ_WAIT = 1: addr = 0x13, wdata = 0xFFFFFFAB, mem_rdata = 0x11223344 -> cycle 3 mem_wr = 1, mem_addr = 0x10, mem_wdata = 0xAB223344; done at cycle 4.
- Half store: addr = 0x22, wdata = 0x0000CAFE, mem_rdata = 0x55667788 -> mem_wdata = 0xCAFE7788 at mem_addr = 0x20. Repeat with BYTE_ORDER = 1 -> 0x5566CAFE.
- Misalignment: size = 01 addr = 0x21; size = 00 addr = 0x22; size = 11 -> each gives misalign pulse at cycle 1, mem_wr stays 0, done stays 0.
- Reset during WAIT of a byte store -> mem_wr, busy and done are 0 immediately and stay 0. A following word store completes normally with the 2-cycle latency.
- start pulsed during busy, then back-to-back stores -> mid-op start ignored with latched data unchanged; a start in the IDLE cycle after done is accepted and completes with correct data.
